instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Front end of Core101. Drives the instruction memory request channel (valid/addr, ready/data)
//   and buffers fetched words with their PC in a small prefetch FIFO. Presents the buffered words
//   to the decode stage over a valid/ready handshake. A redirect input (branch/jump) flushes the
//   FIFO and restarts fetch at the new PC.
// PARAMETERS
//   XLEN        32             data/address width
//   RESET_PC    32'h0000_0000  first fetch address after reset; bits [1:0] must be 0
//   FIFO_DEPTH  2              prefetch entries; power of 2, >= 2
// PORTS
//   clock_in          input   1     core clock; all state updates on its rising edge
//   reset_in          input   1     synchronous, active-high reset
//   ins_mem_valid_out output  1     fetch request valid
//   ins_mem_addr_out  output  XLEN  fetch address (word aligned)
//   ins_mem_ready_in  input   1     memory accepts request; data valid in the same cycle
//   ins_mem_data_in   input   32    instruction word; sampled when valid & ready
//   dec_valid_out     output  1     instruction available to decode
//   dec_ins_out       output  32    instruction word at FIFO head
//   dec_pc_out        output  XLEN  PC of dec_ins_out
//   dec_ready_in      input   1     decode consumes head when dec_valid_out & dec_ready_in
//   redirect_valid_in input   1     flush and restart fetch this cycle
//   redirect_pc_in    input   XLEN  new fetch PC; bits [1:0] ignored (forced to 0)
// BEHAVIOUR
//   State: fetch_pc register, FIFO of {pc, ins} entries, read/write pointers, occupancy count.
//   Reset (reset_in=1 at an edge): fetch_pc<=RESET_PC, FIFO emptied, count<=0.
//   While reset_in=1: ins_mem_valid_out=0 and dec_valid_out=0 (combinationally gated).
//     dec_ins_out/dec_pc_out are don't-care.
//   Request: ins_mem_valid_out = !reset_in & !redirect_valid_in & (count < FIFO_DEPTH).
//     ins_mem_addr_out = fetch_pc.
//   Mem handshake (valid & ready): push {fetch_pc, ins_mem_data_in}; fetch_pc <= fetch_pc+4,
//     modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
//   A pop in the same cycle does not free a slot for that cycle's request (no bypass).
//   Once raised, valid and addr hold stable until ready, except on redirect or reset.
//   Decode: dec_valid_out = !reset_in & !redirect_valid_in & (count != 0).
//     dec_ins_out/dec_pc_out = FIFO head.
//   Decode handshake (valid & ready): pop head.
//   Head is stable while dec_valid_out & !dec_ready_in.
//   Latency: a word accepted at edge N is visible on dec_* in cycle N+1 (if the FIFO was
//     empty); 1 instruction/cycle sustained with both sides ready.
//   Simultaneous push & pop: count unchanged, both pointers advance (wrap mod FIFO_DEPTH).
//   Full: no request issued. Empty: dec_valid_out=0.
//   Redirect (redirect_valid_in=1): no mem or decode handshake occurs that cycle.
//     At the edge: FIFO flushed (count<=0, pointers reset), fetch_pc <= {redirect_pc_in[XLEN-1:2], 2'b00}.
//     First request at the new PC is issued the next cycle.
//   Priority at an edge: reset_in > redirect_valid_in > normal push/pop.
//   Back-to-back redirects: the last one wins. No instruction fetched before a redirect
//     is ever delivered after it.
// TESTING
//   1 RESET_PC=0x100, mem ready=1, dec_ready=1 -> addr 0x100,0x104,0x108...; dec_pc 0x100 one cycle
//     after the first handshake, then one per cycle, in order, with matching data.
//   2 dec_ready=0 from start -> 2 handshakes (0x100,0x104), then valid=0 with addr held at 0x108;
//     head stays 0x100; dec_ready=1 -> 0x100,0x104,0x108 delivered in order, no loss or duplicates.
//   3 ins_mem_ready_in=0 for 3 cycles -> valid=1 and addr held at 0x104 all 3 cycles; no push.
//     Ready=1 -> single push of 0x104.
//   4 FIFO full, redirect_pc_in=0x2003 -> that cycle dec_valid=0, mem valid=0; next cycle addr=0x2000,
//     FIFO empty; the first decoded PC is 0x2000.
//   5 RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000; dec_pc sequence wraps identically.
//   6 reset_in=1 mid-stream, with 1 entry held and a request stalled -> next cycle dec_valid=0, count=0;
//     after release the first addr is RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request channel, decode handshake and redirect.
// The master modport is the fetch unit; the slave modport is memory/decode/branch logic.
interface instruction_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            ins_mem_valid_out;
    logic [XLEN-1:0] ins_mem_addr_out;
    logic            ins_mem_ready_in;
    logic [31:0]     ins_mem_data_in;
    logic            dec_valid_out;
    logic [31:0]     dec_ins_out;
    logic [XLEN-1:0] dec_pc_out;
    logic            dec_ready_in;
    logic            redirect_valid_in;
    logic [XLEN-1:0] redirect_pc_in;

    modport master (
        output ins_mem_valid_out, ins_mem_addr_out,
        input  ins_mem_ready_in, ins_mem_data_in,
        output dec_valid_out, dec_ins_out, dec_pc_out,
        input  dec_ready_in,
        input  redirect_valid_in, redirect_pc_in
    );

    modport slave (
        input  ins_mem_valid_out, ins_mem_addr_out,
        output ins_mem_ready_in, ins_mem_data_in,
        input  dec_valid_out, dec_ins_out, dec_pc_out,
        output dec_ready_in,
        output redirect_valid_in, redirect_pc_in
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Core front end: sequential word fetch into a small prefetch FIFO feeding decode,
// with redirect flushing the FIFO and restarting fetch at the new PC.
module instruction_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input logic                      clock_in,
    input logic                      reset_in,
    instruction_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ins;
    } entry_t;

    entry_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic            mem_fire, dec_fire;

    // Request capacity uses pre-edge occupancy only: a same-cycle pop never frees a slot.
    assign bus.ins_mem_valid_out = !reset_in && !bus.redirect_valid_in
                                   && (count_q < CW'(FIFO_DEPTH));
    assign bus.ins_mem_addr_out  = fetch_pc_q;
    assign bus.dec_valid_out     = !reset_in && !bus.redirect_valid_in && (count_q != '0);
    assign bus.dec_ins_out       = fifo_q[rd_ptr_q].ins;
    assign bus.dec_pc_out        = fifo_q[rd_ptr_q].pc;

    assign mem_fire = bus.ins_mem_valid_out && bus.ins_mem_ready_in;
    assign dec_fire = bus.dec_valid_out && bus.dec_ready_in;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (bus.redirect_valid_in) begin
            fetch_pc_q <= bus.redirect_pc_in & ~XLEN'(3);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (mem_fire) begin
                fetch_pc_q <= fetch_pc_q + XLEN'(4);
                wr_ptr_q   <= wr_ptr_q + PW'(1);
            end
            if (dec_fire)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(mem_fire) - CW'(dec_fire);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clock_in) begin
        if (mem_fire)
            fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, ins: bus.ins_mem_data_in};
    end
endmodule
